// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MIPS multiply/divide unit owning the HI and LO registers.
// Shift-add multiply (LSB first) and restoring divide (MSB first), one bit per clock.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             hi_we_i,
   input  logic             lo_we_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_by_zero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   localparam int CW = $clog2(WIDTH + 1);
   state_t             state_q;
   logic               div_q, sa_q, sb_q, dz_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [2*WIDTH-1:0] acc_q, acc_d, prod_d, res_d;
   logic               sa_d, sb_d, bz_d;
   logic [WIDTH-1:0]   ma_d, mb_d, quo_d, rem_d;
   logic [WIDTH:0]     sum_d, trial_d, diff_d;
   // Multiply keeps the multiplier in acc low half; divide keeps remainder high, dividend/quotient low.
   always_comb begin
      sa_d    = ~op_i[0] & a_i[WIDTH-1];
      sb_d    = ~op_i[0] & b_i[WIDTH-1];
      bz_d    = op_i[1] & (b_i == '0);
      ma_d    = sa_d ? -a_i : a_i;
      mb_d    = sb_d ? -b_i : b_i;
      sum_d   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
      trial_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      diff_d  = trial_d - {1'b0, opnd_q};
      acc_d   = div_q ? {(diff_d[WIDTH] ? trial_d[WIDTH-1:0] : diff_d[WIDTH-1:0]), acc_q[WIDTH-2:0], ~diff_d[WIDTH]}
                      : {sum_d, acc_q[WIDTH-1:1]};
      prod_d  = (sa_q ^ sb_q) ? -acc_q : acc_q;
      quo_d   = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_d   = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      res_d   = dz_q ? acc_q : (div_q ? {rem_d, quo_d} : prod_d);
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         div_by_zero_o <= 1'b0;
         hi_o          <= '0;
         lo_o          <= '0;
         cnt_q         <= '0;
         div_q         <= 1'b0;
         sa_q          <= 1'b0;
         sb_q          <= 1'b0;
         dz_q          <= 1'b0;
         opnd_q        <= '0;
         acc_q         <= '0;
      end else begin
         done_o        <= 1'b0;
         div_by_zero_o <= 1'b0;
         case (state_q)
            IDLE: if (start_i) begin
               div_q   <= op_i[1];
               sa_q    <= sa_d;
               sb_q    <= sb_d;
               dz_q    <= bz_d;
               cnt_q   <= CW'(WIDTH);
               opnd_q  <= op_i[1] ? mb_d : ma_d;
               acc_q   <= bz_d ? {a_i, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, (op_i[1] ? ma_d : mb_d)};
               busy_o  <= 1'b1;
               state_q <= bz_d ? FIX : CALC;
            end else begin
               if (hi_we_i) hi_o <= wdata_i;
               if (lo_we_i) lo_o <= wdata_i;
            end
            CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_q <= FIX;
            end
            FIX: begin
               {hi_o, lo_o}  <= res_d;
               done_o        <= 1'b1;
               div_by_zero_o <= dz_q;
               busy_o        <= 1'b0;
               state_q       <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit; expected HI/LO/latency queued at start, checked on done.
module tb_mult_div_unit;
   localparam int W = 32;
   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           stamp;
      int           lat;
      int           id;
   } exp_t;
   logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
   logic [1:0]   op = '0;
   logic [W-1:0] a = '0, b = '0, wdata = '0;
   logic         busy, done, dz;
   logic [W-1:0] hi, lo;
   exp_t         sb[$];
   int           n_chk = 0, n_fail = 0, cyc = 0, busy_cyc = 0, done_cnt = 0, n_ops = 0;
   mult_div_unit #(.WIDTH(W)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
      .hi_we_i(hi_we), .lo_we_i(lo_we), .wdata_i(wdata), .busy_o(busy), .done_o(done),
      .div_by_zero_o(dz), .hi_o(hi), .lo_o(lo)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, y, ehi, elo, input logic edz);
      exp_t e;
      e.hi = ehi; e.lo = elo; e.dz = edz; e.stamp = cyc; e.lat = edz ? 2 : W + 2; e.id = n_ops++;
      sb.push_back(e);
      start = 1'b1; op = o; a = x; b = y;
      step;
      start = 1'b0;
   endtask
   task automatic wait_idle;
      for (int i = 0; i < W + 10 && sb.size() != 0; i++) step;
      if (sb.size() != 0) begin
         check("timeout", sb.size(), 0);
         sb.delete();
      end
   endtask
   function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, y);
      exp_t e;
      longint sx, sy, p, q, r;
      sx = o[0] ? longint'(x) : longint'($signed(x));
      sy = o[0] ? longint'(y) : longint'($signed(y));
      e.dz = 1'b0; e.stamp = 0; e.lat = 0; e.id = 0;
      if (!o[1]) begin
         p = sx * sy;
         e.hi = p[63:32]; e.lo = p[31:0];
      end else if (y == '0) begin
         e.hi = x; e.lo = '1; e.dz = 1'b1;
      end else begin
         q = sx / sy;
         r = sx % sy;
         e.hi = r[31:0]; e.lo = q[31:0];
      end
      return e;
   endfunction
   // Monitor: every done pulse must match the head of the scoreboard.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!rst_n) busy_cyc = 0;
      else begin
         if (busy) busy_cyc++;
         if (done) begin
            check("busy_done_excl", busy, 0);
            if (sb.size() == 0) check("spurious_done", done, 0);
            else begin
               e = sb.pop_front();
               check($sformatf("op%0d_hi", e.id), hi, e.hi);
               check($sformatf("op%0d_lo", e.id), lo, e.lo);
               check($sformatf("op%0d_dz", e.id), dz, e.dz);
               check($sformatf("op%0d_latency", e.id), cyc - e.stamp, e.lat);
               check($sformatf("op%0d_busy_cycles", e.id), busy_cyc, e.lat - 1);
            end
            busy_cyc = 0;
            done_cnt++;
         end else if (dz) check("dz_without_done", dz, 0);
      end
   end
   initial begin
      exp_t e;
      int   dc, r;
      logic [1:0] o;
      logic [W-1:0] x, y;
      step; step;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dz", dz, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      rst_n = 1'b1;
      step;
      start_op(2'b00, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0); wait_idle;
      start_op(2'b01, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA, 1'b0); wait_idle;
      start_op(2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0); wait_idle;
      start_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0); wait_idle;
      start_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0); wait_idle;
      start_op(2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1'b1); wait_idle;
      hi_we = 1'b1; wdata = 32'hDEADBEEF;
      step;
      hi_we = 1'b0;
      check("mthi_hi", hi, 32'hDEADBEEF);
      check("mthi_lo_kept", lo, 32'hFFFFFFFF);
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0F0F0F0F;
      step;
      hi_we = 1'b0; lo_we = 1'b0;
      check("both_we_hi", hi, 32'h0F0F0F0F);
      check("both_we_lo", lo, 32'h0F0F0F0F);
      hi_we = 1'b1; wdata = 32'hAAAA;
      start_op(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
      hi_we = 1'b0;
      check("start_drops_mthi", hi, 32'h0F0F0F0F);
      wait_idle;
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0F0F0F0F;
      step;
      hi_we = 1'b0; lo_we = 1'b0;
      start_op(2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);
      repeat (9) step;
      start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd3; hi_we = 1'b1; wdata = 32'h1234;
      step;
      start = 1'b0; hi_we = 1'b0;
      check("inflight_busy", busy, 1);
      check("inflight_hi_held", hi, 32'h0F0F0F0F);
      check("inflight_lo_held", lo, 32'h0F0F0F0F);
      for (int i = 0; i < W + 10 && !done; i++) step;
      check("b2b_done_seen", done, 1);
      start_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      wait_idle;
      start_op(2'b00, 32'h12345, 32'hFFFF0000, 32'hFFFFFFFE, 32'hDCBB0000, 1'b0);
      repeat (14) step;
      check("pre_reset_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_busy", busy, 0);
      check("async_rst_done", done, 0);
      check("async_rst_hi", hi, 0);
      check("async_rst_lo", lo, 0);
      sb.delete();
      step;
      rst_n = 1'b1;
      dc = done_cnt;
      repeat (W + 10) step;
      check("no_done_after_reset", done_cnt, dc);
      for (int i = 0; i < 300; i++) begin
         o = 2'($urandom_range(0, 3));
         x = (i % 17 == 0) ? 32'h80000000 : $urandom;
         r = $urandom_range(0, 9);
         y = (r == 0) ? 32'd0 : (r == 1) ? W'($urandom_range(1, 15)) : (r == 2) ? 32'hFFFFFFFF : $urandom;
         e = model(o, x, y);
         start_op(o, x, y, e.hi, e.lo, e.dz);
         wait_idle;
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
